sipo_rx: RTL and testbench

Serial-in parallel-out receiver: the receiving end of the `piso` serial link. It samples one bit per clock while `sel` is high, assembles `WIDTH`-bit words, and presents each completed word on a valid/ready output port with overrun detection. It sits between the serial line and the parallel consumer logic, and mirrors the `piso` transmitter's framing.

---
 rtl/sipo_rx.sv | 97 +++++++++
 tb/tb_sipo_rx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_rx.sv
// Serial-in parallel-out receiver with a valid/ready output and a sticky overrun flag.
// Define SIPO_MSB_FIRST_EN for MSB-first assembly; LSB-first otherwise.
module sipo_rx #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic             inbit,
  input  logic             data_ready,
  input  logic             ovr_clr,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] shifted;
  logic             done;
  logic             ovr_set;

`ifdef SIPO_MSB_FIRST_EN
  assign shifted = {sh_q[WIDTH-2:0], inbit};
`else
  assign shifted = {inbit, sh_q[WIDTH-1:1]};
`endif

  always_comb begin
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    dout_d  = dout_q;
    valid_d = valid_q && !data_ready;
    ovr_set = 1'b0;
    done    = 1'b0;

    if (sel) begin
      sh_d = shifted;
      if (cnt_q == LAST) begin
        cnt_d = '0;
        done  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end

    // A transfer on the completion edge frees the output slot for the new word.
    if (done) begin
      if (!valid_q || data_ready) begin
        dout_d  = shifted;
        valid_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end

    if (ovr_set)      ovr_d = 1'b1;
    else if (ovr_clr) ovr_d = 1'b0;
    else              ovr_d = ovr_q;

    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      sh_q    <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  assign data_out   = dout_q;
  assign data_valid = valid_q;
  assign busy       = busy_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_sipo_rx.sv
// Self-checking bench for sipo_rx: directed vector table, reset sequences, and
// randomized traffic against a bit-queue reference model.
module tb_sipo_rx;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         sel = 1'b0;
  logic         inbit = 1'b0;
  logic         data_ready = 1'b0;
  logic         ovr_clr = 1'b0;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic         busy;
  logic         overrun;

  int n_cmp = 0;
  int n_bad = 0;

  sipo_rx #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .sel        (sel),
    .inbit      (inbit),
    .data_ready (data_ready),
    .ovr_clr    (ovr_clr),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Reference model: collected bits of the current word plus the output stage.
  bit           m_bits[$];
  logic [W-1:0] m_dout;
  logic         m_valid;
  logic         m_ovr;

  function automatic logic [W-1:0] ord(input logic [W-1:0] w);
    logic [W-1:0] r;
`ifdef SIPO_MSB_FIRST_EN
    for (int i = 0; i < W; i++) r[i] = w[W-1-i];
`else
    r = w;
`endif
    return r;
  endfunction

  task automatic model_reset();
    m_bits.delete();
    m_dout  = '0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endtask

  task automatic model_edge();
    logic [W-1:0] word;
    bit           done;
    bit           old_valid;
    bit           set;
    done = 0;
    set  = 0;
    word = '0;
    if (sel) begin
      m_bits.push_back(inbit);
      if (m_bits.size() == W) begin
        for (int i = 0; i < W; i++) begin
`ifdef SIPO_MSB_FIRST_EN
          word[W-1-i] = m_bits[i];
`else
          word[i] = m_bits[i];
`endif
        end
        m_bits.delete();
        done = 1;
      end
    end else begin
      m_bits.delete();
    end
    old_valid = m_valid;
    if (m_valid && data_ready) m_valid = 1'b0;
    if (done) begin
      if (!old_valid || data_ready) begin
        m_dout  = word;
        m_valid = 1'b1;
      end else begin
        set = 1;
      end
    end
    if (set) m_ovr = 1'b1;
    else if (ovr_clr) m_ovr = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic b, input logic r, input logic c);
    sel = s; inbit = b; data_ready = r; ovr_clr = c;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [W-1:0] d, input logic v,
                         input logic bz, input logic o);
    chk({tag, ".data_out"},   32'(data_out),   32'(d));
    chk({tag, ".data_valid"}, 32'(data_valid), 32'(v));
    chk({tag, ".busy"},       32'(busy),       32'(bz));
    chk({tag, ".overrun"},    32'(overrun),    32'(o));
  endtask

  typedef struct {
    logic         sel;
    logic         bit_in;
    logic         rdy;
    logic         clr;
    logic [W-1:0] dout;
    logic         valid;
    logic         busy;
    logic         ovr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic s, input logic b, input logic r, input logic c,
                              input logic [W-1:0] d, input logic v, input logic bz,
                              input logic o);
    vec_t x;
    x.sel = s; x.bit_in = b; x.rdy = r; x.clr = c;
    x.dout = d; x.valid = v; x.busy = bz; x.ovr = o;
    return x;
  endfunction

  initial begin
    // Expected data_out values are written LSB-first and passed through ord().
    // basic receive, ready held high
    vecs.push_back(mk(1,1,1,0, 4'b0000,0,1,0));
    vecs.push_back(mk(1,0,1,0, 4'b0000,0,1,0));
    vecs.push_back(mk(1,1,1,0, 4'b0000,0,1,0));
    vecs.push_back(mk(1,0,1,0, 4'b0101,1,0,0));
    vecs.push_back(mk(0,0,1,0, 4'b0101,0,0,0));
    // abort after two bits
    vecs.push_back(mk(1,1,1,0, 4'b0101,0,1,0));
    vecs.push_back(mk(1,1,1,0, 4'b0101,0,1,0));
    vecs.push_back(mk(0,0,1,0, 4'b0101,0,0,0));
    vecs.push_back(mk(1,0,1,0, 4'b0101,0,1,0));
    vecs.push_back(mk(1,0,1,0, 4'b0101,0,1,0));
    vecs.push_back(mk(1,1,1,0, 4'b0101,0,1,0));
    vecs.push_back(mk(1,1,1,0, 4'b1100,1,0,0));
    vecs.push_back(mk(0,0,1,0, 4'b1100,0,0,0));
    // back-pressure: 0011 then 1111 back-to-back
    vecs.push_back(mk(1,1,0,0, 4'b1100,0,1,0));
    vecs.push_back(mk(1,1,0,0, 4'b1100,0,1,0));
    vecs.push_back(mk(1,0,0,0, 4'b1100,0,1,0));
    vecs.push_back(mk(1,0,0,0, 4'b0011,1,0,0));
    vecs.push_back(mk(1,1,0,0, 4'b0011,1,1,0));
    vecs.push_back(mk(1,1,0,0, 4'b0011,1,1,0));
    vecs.push_back(mk(1,1,0,0, 4'b0011,1,1,0));
    vecs.push_back(mk(1,1,0,0, 4'b0011,1,0,1));
    vecs.push_back(mk(0,0,0,1, 4'b0011,1,0,0));
    vecs.push_back(mk(0,0,1,0, 4'b0011,0,0,0));
    // accept and complete on the same edge
    vecs.push_back(mk(1,1,0,0, 4'b0011,0,1,0));
    vecs.push_back(mk(1,0,0,0, 4'b0011,0,1,0));
    vecs.push_back(mk(1,0,0,0, 4'b0011,0,1,0));
    vecs.push_back(mk(1,0,0,0, 4'b0001,1,0,0));
    vecs.push_back(mk(1,0,0,0, 4'b0001,1,1,0));
    vecs.push_back(mk(1,0,0,0, 4'b0001,1,1,0));
    vecs.push_back(mk(1,0,0,0, 4'b0001,1,1,0));
    vecs.push_back(mk(1,1,1,0, 4'b1000,1,0,0));
    vecs.push_back(mk(0,0,1,0, 4'b1000,0,0,0));
    // overrun set coinciding with ovr_clr: set wins
    vecs.push_back(mk(1,0,0,0, 4'b1000,0,1,0));
    vecs.push_back(mk(1,1,0,0, 4'b1000,0,1,0));
    vecs.push_back(mk(1,0,0,0, 4'b1000,0,1,0));
    vecs.push_back(mk(1,0,0,0, 4'b0010,1,0,0));
    vecs.push_back(mk(1,1,0,1, 4'b0010,1,1,0));
    vecs.push_back(mk(1,1,0,1, 4'b0010,1,1,0));
    vecs.push_back(mk(1,1,0,1, 4'b0010,1,1,0));
    vecs.push_back(mk(1,1,0,1, 4'b0010,1,0,1));
    vecs.push_back(mk(0,0,1,1, 4'b0010,0,0,0));

    // reset held low with toggling inputs
    model_reset();
    for (int i = 0; i < 6; i++) begin
      sel = 1'($urandom); inbit = 1'($urandom);
      data_ready = 1'($urandom); ovr_clr = 1'($urandom);
      @(posedge clk);
      #1;
      chk_all("in_reset", '0, 0, 0, 0);
    end
    sel = 0; inbit = 0; data_ready = 0; ovr_clr = 0;
    #3 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      chk_all("post_reset_idle", '0, 0, 0, 0);
    end

    // directed table
    for (int unsigned i = 0; i < vecs.size(); i++) begin
      step(vecs[i].sel, vecs[i].bit_in, vecs[i].rdy, vecs[i].clr);
      chk_all($sformatf("vec%0d", i), ord(vecs[i].dout), vecs[i].valid,
              vecs[i].busy, vecs[i].ovr);
    end

    // reset asserted between edges in the middle of a word
    step(1, 1, 1, 0);
    step(1, 1, 1, 0);
    chk("midword.busy_before", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk_all("midword_async", '0, 0, 0, 0);
    model_reset();
    #2 rst = 1'b1;
    step(1, 0, 1, 0);
    step(1, 1, 1, 0);
    step(1, 1, 1, 0);
    step(1, 0, 1, 0);
    chk_all("after_reset_word", ord(4'b0110), 1, 0, 0);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) < 88) ? 1'b1 : 1'b0, 1'($urandom),
           ($urandom_range(0, 99) < 45) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0);
      chk_all("rand", m_dout, m_valid, (m_bits.size() != 0), m_ovr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
